action_aligner: RTL and testbench

ACTION_ALIGNER -- requirements
Module: action_aligner

---
 rtl/action_aligner_pkg.sv | 20 ++
 rtl/action_aligner_if.sv | 39 +++
 rtl/action_aligner_fifo.sv | 55 +++++
 rtl/action_aligner.sv | 70 +++++++
 tb/tb_action_aligner.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/action_aligner_pkg.sv
// Shared switch parameters: result field widths and the packed action-result record
// carried through the per-engine alignment FIFOs.
package action_aligner_pkg;

  localparam int unsigned C_OUT_PORT_WIDTH   = 4;
  localparam int unsigned C_MATCH_ADDR_WIDTH = 8;

  typedef struct packed {
    logic [1:0]                    act_type;
    logic                          match;
    logic [C_MATCH_ADDR_WIDTH-1:0] match_addr;
    logic [C_OUT_PORT_WIDTH-1:0]   port;
    logic [C_OUT_PORT_WIDTH-1:0]   vport;
  } action_result_t;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/action_aligner_if.sv
// Bundle of per-engine lookup results in, aligned results out, plus FIFO status.
interface action_aligner_if
  import action_aligner_pkg::*;
#(
  parameter int unsigned C_NUM_INPUTS = 2,
  parameter int unsigned C_FIFO_DEPTH = 4
);
  localparam int unsigned LW = level_width(C_FIFO_DEPTH);

  logic [C_NUM_INPUTS-1:0]                         in_valid;
  logic [C_NUM_INPUTS-1:0][1:0]                    in_type;
  logic [C_NUM_INPUTS-1:0]                         in_match;
  logic [C_NUM_INPUTS-1:0][C_MATCH_ADDR_WIDTH-1:0] in_match_addr;
  logic [C_NUM_INPUTS-1:0][C_OUT_PORT_WIDTH-1:0]   in_port;
  logic [C_NUM_INPUTS-1:0][C_OUT_PORT_WIDTH-1:0]   in_vport;

  logic [C_NUM_INPUTS-1:0]                         out_valid;
  logic [C_NUM_INPUTS-1:0][1:0]                    out_type;
  logic [C_NUM_INPUTS-1:0]                         out_match;
  logic [C_NUM_INPUTS-1:0][C_MATCH_ADDR_WIDTH-1:0] out_match_addr;
  logic [C_NUM_INPUTS-1:0][C_OUT_PORT_WIDTH-1:0]   out_port;
  logic [C_NUM_INPUTS-1:0][C_OUT_PORT_WIDTH-1:0]   out_vport;

  logic [C_NUM_INPUTS-1:0]                         overflow;
  logic [C_NUM_INPUTS-1:0][LW-1:0]                 level;

  modport master (
    output in_valid, in_type, in_match, in_match_addr, in_port, in_vport,
    input  out_valid, out_type, out_match, out_match_addr, out_port, out_vport,
    input  overflow, level
  );

  modport slave (
    input  in_valid, in_type, in_match, in_match_addr, in_port, in_vport,
    output out_valid, out_type, out_match, out_match_addr, out_port, out_vport,
    output overflow, level
  );

endinterface

// File: rtl/action_aligner_fifo.sv
// Per-engine result FIFO. A push into a full FIFO is accepted only when a pop frees
// the slot in the same cycle; the empty flag comes from the registered level (no bypass).
module action_fifo
  import action_aligner_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = level_width(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  action_result_t push_data,
  input  logic           pop,
  output action_result_t pop_data,
  output logic           full,
  output logic           empty,
  output logic [LW-1:0]  level
);

  localparam int unsigned PW = $clog2(DEPTH);

  action_result_t mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           wr_en;
  logic           rd_en;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_en && !rd_en) begin
        level <= level + LW'(1);
      end else if (rd_en && !wr_en) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/action_aligner.sv
// Aligns results from several lookup engines: one FIFO per engine, and all FIFOs pop
// together whenever every one holds a result, producing one registered aligned strobe.
module action_aligner
  import action_aligner_pkg::*;
#(
  parameter int unsigned C_NUM_INPUTS = 2,
  parameter int unsigned C_FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  action_aligner_if.slave bus
);

  logic [C_NUM_INPUTS-1:0] full;
  logic [C_NUM_INPUTS-1:0] empty;
  action_result_t          head [C_NUM_INPUTS];
  logic                    rel;

  assign rel = ~|empty;

  for (genvar g = 0; g < C_NUM_INPUTS; g++) begin : g_engine
    action_result_t wr;

    assign wr.act_type   = bus.in_type[g];
    assign wr.match      = bus.in_match[g];
    assign wr.match_addr = bus.in_match_addr[g];
    assign wr.port       = bus.in_port[g];
    assign wr.vport      = bus.in_vport[g];

    action_fifo #(.DEPTH(C_FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.in_valid[g]),
      .push_data (wr),
      .pop       (rel),
      .pop_data  (head[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .level     (bus.level[g])
    );
  end

  // Data outputs only load on a release, so they hold between aligned strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid      <= '0;
      bus.out_type       <= '0;
      bus.out_match      <= '0;
      bus.out_match_addr <= '0;
      bus.out_port       <= '0;
      bus.out_vport      <= '0;
      bus.overflow       <= '0;
    end else begin
      bus.out_valid <= {C_NUM_INPUTS{rel}};
      for (int unsigned i = 0; i < C_NUM_INPUTS; i++) begin
        if (rel) begin
          bus.out_type[i]       <= head[i].act_type;
          bus.out_match[i]      <= head[i].match;
          bus.out_match_addr[i] <= head[i].match_addr;
          bus.out_port[i]       <= head[i].port;
          bus.out_vport[i]      <= head[i].vport;
        end
        if (bus.in_valid[i] && full[i] && !rel) begin
          bus.overflow[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_action_aligner.sv
// Bench for action_aligner: reference queues per engine, a release scoreboard,
// a table of hand-computed vectors and directed latency sequences.
module tb_action_aligner;
  import action_aligner_pkg::*;

  localparam int unsigned N = 2;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  action_aligner_if #(.C_NUM_INPUTS(N), .C_FIFO_DEPTH(D)) bus ();

  action_aligner #(.C_NUM_INPUTS(N), .C_FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    action_result_t r1;
    action_result_t r0;
  } pair_t;

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [3:0] p0;
    logic [3:0] p1;
    logic       ov;
    logic [3:0] e0;
    logic [3:0] e1;
    logic [2:0] l0;
    logic [2:0] l1;
    logic [1:0] ovf;
  } vec_t;

  int             n_checks = 0;
  int             n_errors = 0;
  action_result_t q0[$];
  action_result_t q1[$];
  pair_t          exp_q[$];
  pair_t          m_last;
  logic           m_valid;
  logic [1:0]     m_ovf;
  int             cyc;
  logic [31:0]    seen;
  logic [3:0]     cap0;
  logic [3:0]     cap1;
  vec_t           tbl [29];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic action_result_t mk(input logic [3:0] p);
    action_result_t r;
    r.act_type   = p[1:0];
    r.match      = p[0];
    r.match_addr = {4'h5, p};
    r.port       = p;
    r.vport      = ~p;
    return r;
  endfunction

  function automatic action_result_t rnd();
    action_result_t r;
    r.act_type   = 2'($urandom);
    r.match      = 1'($urandom);
    r.match_addr = 8'($urandom);
    r.port       = 4'($urandom);
    r.vport      = 4'($urandom);
    return r;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic [1:0] v, input logic [3:0] p0,
                               input logic [3:0] p1, input logic ov, input logic [3:0] e0,
                               input logic [3:0] e1, input logic [2:0] l0, input logic [2:0] l1,
                               input logic [1:0] ovf);
    vec_t t;
    t.rst = rst; t.v = v; t.p0 = p0; t.p1 = p1; t.ov = ov;
    t.e0 = e0; t.e1 = e1; t.l0 = l0; t.l1 = l1; t.ovf = ovf;
    return t;
  endfunction

  task automatic check_cycle();
    action_result_t a0;
    action_result_t a1;
    chk("out_valid", 32'(bus.out_valid), 32'({N{m_valid}}));
    chk("valid_bits_equal", 32'(bus.out_valid[0] == bus.out_valid[1]), 32'd1);
    if (bus.out_valid[0]) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard (cycle %0d): got unexpected out_valid, required no release", cyc);
      end else begin
        m_last = exp_q.pop_front();
      end
    end
    a0 = '{bus.out_type[0], bus.out_match[0], bus.out_match_addr[0], bus.out_port[0], bus.out_vport[0]};
    a1 = '{bus.out_type[1], bus.out_match[1], bus.out_match_addr[1], bus.out_port[1], bus.out_vport[1]};
    chk("data0", 32'(a0), 32'(m_last.r0));
    chk("data1", 32'(a1), 32'(m_last.r1));
    chk("level0", 32'(bus.level[0]), 32'(q0.size()));
    chk("level1", 32'(bus.level[1]), 32'(q1.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (cyc < 32) seen[cyc] = bus.out_valid[0];
    if (bus.out_valid[0]) begin
      cap0 = bus.out_port[0];
      cap1 = bus.out_port[1];
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] v, input action_result_t d0,
                      input action_result_t d1);
    logic rel;
    reset                = rst;
    bus.in_valid         = v;
    bus.in_type[0]       = d0.act_type;   bus.in_type[1]       = d1.act_type;
    bus.in_match[0]      = d0.match;      bus.in_match[1]      = d1.match;
    bus.in_match_addr[0] = d0.match_addr; bus.in_match_addr[1] = d1.match_addr;
    bus.in_port[0]       = d0.port;       bus.in_port[1]       = d1.port;
    bus.in_vport[0]      = d0.vport;      bus.in_vport[1]      = d1.vport;
    if (rst) begin
      q0.delete();
      q1.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_ovf   = '0;
      m_last  = '0;
      cyc     = 0;
      seen    = '0;
    end else begin
      rel     = (q0.size() > 0) && (q1.size() > 0);
      m_valid = rel;
      if (rel) exp_q.push_back('{r1: q1.pop_front(), r0: q0.pop_front()});
      if (v[0]) begin
        if (q0.size() < D) q0.push_back(d0);
        else m_ovf[0] = 1'b1;
      end
      if (v[1]) begin
        if (q1.size() < D) q1.push_back(d1);
        else m_ovf[1] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  initial begin
    int c0;
    int c1;
    logic [1:0] v;

    //            rst  v     p0 p1 ov e0 e1 l0 l1 ovf
    tbl[0]  = mkv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tbl[1]  = mkv(0, 2'b01, 1, 0, 0, 0, 0, 1, 0, 2'b00);
    tbl[2]  = mkv(0, 2'b01, 2, 0, 0, 0, 0, 2, 0, 2'b00);
    tbl[3]  = mkv(0, 2'b01, 3, 0, 0, 0, 0, 3, 0, 2'b00);
    tbl[4]  = mkv(0, 2'b01, 4, 0, 0, 0, 0, 4, 0, 2'b00);
    tbl[5]  = mkv(0, 2'b01, 5, 0, 0, 0, 0, 4, 0, 2'b01);
    tbl[6]  = mkv(0, 2'b10, 0, 1, 0, 0, 0, 4, 1, 2'b01);
    tbl[7]  = mkv(0, 2'b10, 0, 2, 1, 1, 1, 3, 1, 2'b01);
    tbl[8]  = mkv(0, 2'b10, 0, 3, 1, 2, 2, 2, 1, 2'b01);
    tbl[9]  = mkv(0, 2'b10, 0, 4, 1, 3, 3, 1, 1, 2'b01);
    tbl[10] = mkv(0, 2'b00, 0, 0, 1, 4, 4, 0, 0, 2'b01);
    tbl[11] = mkv(0, 2'b00, 0, 0, 0, 4, 4, 0, 0, 2'b01);
    tbl[12] = mkv(1, 2'b11, 9, 9, 0, 0, 0, 0, 0, 2'b00);
    tbl[13] = mkv(0, 2'b01, 6, 0, 0, 0, 0, 1, 0, 2'b00);
    tbl[14] = mkv(0, 2'b01, 7, 0, 0, 0, 0, 2, 0, 2'b00);
    tbl[15] = mkv(0, 2'b01, 8, 0, 0, 0, 0, 3, 0, 2'b00);
    tbl[16] = mkv(0, 2'b01, 9, 0, 0, 0, 0, 4, 0, 2'b00);
    tbl[17] = mkv(0, 2'b10, 0, 6, 0, 0, 0, 4, 1, 2'b00);
    tbl[18] = mkv(0, 2'b11, 10, 7, 1, 6, 6, 4, 1, 2'b00);
    tbl[19] = mkv(0, 2'b00, 0, 0, 1, 7, 7, 3, 0, 2'b00);
    tbl[20] = mkv(0, 2'b00, 0, 0, 0, 7, 7, 3, 0, 2'b00);
    tbl[21] = mkv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tbl[22] = mkv(0, 2'b01, 1, 0, 0, 0, 0, 1, 0, 2'b00);
    tbl[23] = mkv(0, 2'b01, 2, 0, 0, 0, 0, 2, 0, 2'b00);
    tbl[24] = mkv(1, 2'b10, 0, 5, 0, 0, 0, 0, 0, 2'b00);
    tbl[25] = mkv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tbl[26] = mkv(0, 2'b11, 3, 3, 0, 0, 0, 1, 1, 2'b00);
    tbl[27] = mkv(0, 2'b00, 0, 0, 1, 3, 3, 0, 0, 2'b00);
    tbl[28] = mkv(0, 2'b00, 0, 0, 0, 3, 3, 0, 0, 2'b00);

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].rst, tbl[i].v, mk(tbl[i].p0), mk(tbl[i].p1));
      chk("tbl_valid", 32'(bus.out_valid), 32'({N{tbl[i].ov}}));
      chk("tbl_port0", 32'(bus.out_port[0]), 32'(tbl[i].e0));
      chk("tbl_port1", 32'(bus.out_port[1]), 32'(tbl[i].e1));
      chk("tbl_level0", 32'(bus.level[0]), 32'(tbl[i].l0));
      chk("tbl_level1", 32'(bus.level[1]), 32'(tbl[i].l1));
      chk("tbl_overflow", 32'(bus.overflow), 32'(tbl[i].ovf));
    end

    // Skewed arrival: engine0 in cycle 10, engine1 in cycle 14, aligned strobe in cycle 16.
    step(1'b1, 2'b00, mk(0), mk(0));
    for (int k = 1; k < 20; k++) begin
      v = (k == 10) ? 2'b01 : (k == 14) ? 2'b10 : 2'b00;
      step(1'b0, v, mk(3), mk(5));
    end
    chk("skew_valid_cycles", seen, 32'h0001_0000);
    chk("skew_port0", 32'(cap0), 32'd3);
    chk("skew_port1", 32'(cap1), 32'd5);

    // Simultaneous pushes in cycles 10..12 appear in cycles 12..14, in push order.
    step(1'b1, 2'b00, mk(0), mk(0));
    for (int k = 1; k < 20; k++) begin
      v = (k >= 10 && k <= 12) ? 2'b11 : 2'b00;
      step(1'b0, v, mk(4'(k - 9)), mk(4'(k + 1)));
    end
    chk("b2b_valid_cycles", seen, 32'h0000_7000);
    chk("b2b_last_port0", 32'(cap0), 32'd3);
    chk("b2b_last_port1", 32'(cap1), 32'd13);

    // Random skew of at most 3 results between engines, 1000 results each.
    step(1'b1, 2'b00, mk(0), mk(0));
    c0 = 0;
    c1 = 0;
    while (c0 < 1000 || c1 < 1000) begin
      v = 2'($urandom_range(0, 3));
      if (c0 >= 1000 || (c0 - c1) >= 3) v[0] = 1'b0;
      if (c1 >= 1000 || (c1 - c0) >= 3) v[1] = 1'b0;
      if (v[0]) c0++;
      if (v[1]) c1++;
      step(1'b0, v, rnd(), rnd());
    end
    for (int k = 0; k < 6; k++) step(1'b0, 2'b00, rnd(), rnd());
    chk("rand_no_overflow", 32'(bus.overflow), 32'd0);
    chk("rand_drained0", 32'(bus.level[0]), 32'd0);
    chk("rand_drained1", 32'(bus.level[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
